// File: rtl/axi4_lite_mul_pkg.sv
// Shared types, response codes, register bit positions and address map helpers
// for the AXI4-Lite multiplier slave.
package axi4_lite_mul_pkg;

    localparam logic RESP_OK  = 1'b1;
    localparam logic RESP_ERR = 1'b0;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_IEN      = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // Word addresses of each register block, as a function of chunks per operand.
    function automatic int a_base(input int na);
        return 0 * na;
    endfunction

    function automatic int b_base(input int na);
        return na;
    endfunction

    function automatic int res_base(input int na);
        return 2 * na;
    endfunction

    function automatic int ctrl_addr(input int na);
        return 4 * na;
    endfunction

    function automatic int stat_addr(input int na);
        return 4 * na + 1;
    endfunction

endpackage

// File: rtl/axi4_lite_seq_mul.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle; the
// result register updates and done rises exactly SZ cycles after busy rises.
module axi4_lite_seq_mul #(
    parameter int SZ = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            clr_done_i,
    input  logic [SZ-1:0]   a_i,
    input  logic [SZ-1:0]   b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [2*SZ-1:0] product_o
);

    localparam int CW = $clog2(SZ + 1);

    logic [2*SZ-1:0] mcand_q;
    logic [2*SZ-1:0] acc_q;
    logic [2*SZ-1:0] res_q;
    logic [2*SZ-1:0] acc_d;
    logic [SZ-1:0]   mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{SZ{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            // Completion overrides a clear arriving on the same edge.
            if (clr_done_i) begin
                done_q <= 1'b0;
            end
            if (busy_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(SZ - 1)) begin
                    res_q  <= acc_d;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = res_q;

endmodule

// File: rtl/axi4_lite_mul_slave.sv
// AXI4-Lite register front end for the sequential multiplier: operand chunks,
// result chunks, CTRL and STATUS. Define AXI_LITE_MUL_IRQ_EN for the done interrupt.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both high; valid, once raised, holds with stable payload
// until that edge.
module axi4_lite_mul_slave
    import axi4_lite_mul_pkg::*;
#(
    parameter int SZ  = 32,
    parameter int DSZ = 8,
    parameter int ASZ = 5
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [ASZ-1:0] awaddr,
    input  logic           awvalid,
    output logic           awready,
    input  logic [DSZ-1:0] wdata,
    input  logic           wvalid,
    output logic           wready,
    output logic           bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [ASZ-1:0] araddr,
    input  logic           arvalid,
    output logic           arready,
    output logic [DSZ-1:0] rdata,
    output logic           rresp,
    output logic           rvalid,
    input  logic           rready,
`ifdef AXI_LITE_MUL_IRQ_EN
    output logic           irq,
`endif
    output wr_state_e      dbg_wr_state_o,
    output rd_state_e      dbg_rd_state_o
);

    localparam int NA = SZ / DSZ;

    wr_state_e       wr_state_q, wr_state_d;
    rd_state_e       rd_state_q, rd_state_d;
    logic            out_of_rst_q;
    logic [ASZ-1:0]  awaddr_q;
    logic [DSZ-1:0]  wdata_q;
    logic            bresp_q;
    logic [DSZ-1:0]  rdata_q;
    logic            rresp_q;
    logic [SZ-1:0]   a_q, a_d;
    logic [SZ-1:0]   b_q, b_d;
    logic            aw_hs, w_hs, ar_hs, wr_fire;
    logic [ASZ-1:0]  wr_addr;
    logic [DSZ-1:0]  wr_data;
    logic [31:0]     wr_addr_x, rd_addr_x;
    logic            wr_ok, rd_ok;
    logic [DSZ-1:0]  rd_data;
    logic            mul_start, mul_clr, busy, done;
    logic [2*SZ-1:0] product;
`ifdef AXI_LITE_MUL_IRQ_EN
    logic            ien_q, ien_d;
`endif

    // Readies stay low while reset is asserted and until the first edge after release.
    assign awready = out_of_rst_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_W);
    assign wready  = out_of_rst_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_AW);
    assign arready = out_of_rst_q && (rd_state_q == RD_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_fire    = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = WR_RESP;
                    wr_fire    = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    wr_state_d = WR_RESP;
                    wr_fire    = 1'b1;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    wr_state_d = WR_RESP;
                    wr_fire    = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // The half that completes the pair is taken straight from the bus.
    assign wr_addr   = (wr_state_q == WR_HAVE_AW) ? awaddr_q : awaddr;
    assign wr_data   = (wr_state_q == WR_HAVE_W) ? wdata_q : wdata;
    assign wr_addr_x = 32'(wr_addr);
    assign rd_addr_x = 32'(araddr);

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        wr_ok     = RESP_ERR;
        mul_start = 1'b0;
        mul_clr   = 1'b0;
`ifdef AXI_LITE_MUL_IRQ_EN
        ien_d     = ien_q;
`endif
        for (int k = 0; k < NA; k++) begin
            if (wr_addr_x == 32'(a_base(NA) + k)) begin
                wr_ok = !busy;
                if (wr_fire && !busy) a_d[k*DSZ +: DSZ] = wr_data;
            end
            if (wr_addr_x == 32'(b_base(NA) + k)) begin
                wr_ok = !busy;
                if (wr_fire && !busy) b_d[k*DSZ +: DSZ] = wr_data;
            end
        end
        if (wr_addr_x == 32'(ctrl_addr(NA))) begin
            wr_ok = !(wr_data[CTRL_START] && busy);
            if (wr_fire && wr_ok) begin
                mul_start = wr_data[CTRL_START];
                mul_clr   = wr_data[CTRL_CLR_DONE];
`ifdef AXI_LITE_MUL_IRQ_EN
                ien_d     = wr_data[CTRL_IEN];
`endif
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read decode sees pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        rd_data = '0;
        rd_ok   = RESP_ERR;
        for (int k = 0; k < NA; k++) begin
            if (rd_addr_x == 32'(a_base(NA) + k)) begin
                rd_ok   = RESP_OK;
                rd_data = a_q[k*DSZ +: DSZ];
            end
            if (rd_addr_x == 32'(b_base(NA) + k)) begin
                rd_ok   = RESP_OK;
                rd_data = b_q[k*DSZ +: DSZ];
            end
        end
        for (int j = 0; j < 2 * NA; j++) begin
            if (rd_addr_x == 32'(res_base(NA) + j)) begin
                rd_ok = !busy;
                if (!busy) rd_data = product[j*DSZ +: DSZ];
            end
        end
        if (rd_addr_x == 32'(ctrl_addr(NA))) begin
            rd_ok = RESP_OK;
`ifdef AXI_LITE_MUL_IRQ_EN
            rd_data[CTRL_IEN] = ien_q;
`endif
        end
        if (rd_addr_x == 32'(stat_addr(NA))) begin
            rd_ok              = RESP_OK;
            rd_data[STAT_BUSY] = busy;
            rd_data[STAT_DONE] = done;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            out_of_rst_q <= 1'b0;
            wr_state_q   <= WR_IDLE;
            rd_state_q   <= RD_IDLE;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            bresp_q      <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
`ifdef AXI_LITE_MUL_IRQ_EN
            ien_q        <= 1'b0;
`endif
        end else begin
            out_of_rst_q <= 1'b1;
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) wdata_q <= wdata;
            if (wr_fire) bresp_q <= wr_ok;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_ok;
            end
            a_q <= a_d;
            b_q <= b_d;
`ifdef AXI_LITE_MUL_IRQ_EN
            ien_q <= ien_d;
`endif
        end
    end

    axi4_lite_seq_mul #(.SZ(SZ)) u_mul (
        .clk        (clk),
        .rst_n      (_rst),
        .start_i    (mul_start),
        .clr_done_i (mul_clr),
        .a_i        (a_q),
        .b_i        (b_q),
        .busy_o     (busy),
        .done_o     (done),
        .product_o  (product)
    );

    assign bvalid         = (wr_state_q == WR_RESP);
    assign bresp          = bresp_q;
    assign rvalid         = (rd_state_q == RD_RESP);
    assign rdata          = rdata_q;
    assign rresp          = rresp_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;
`ifdef AXI_LITE_MUL_IRQ_EN
    assign irq            = done && ien_q;
`endif

endmodule

// File: tb/tb_axi4_lite_mul_slave.sv
// Directed bench for axi4_lite_mul_slave at SZ=32, DSZ=8, ASZ=5; the irq test
// is compiled in only when AXI_LITE_MUL_IRQ_EN is defined.
module tb_axi4_lite_mul_slave;

    localparam int SZ   = 32;
    localparam int DSZ  = 8;
    localparam int ASZ  = 5;
    localparam logic [ASZ-1:0] RES0 = 5'd8;
    localparam logic [ASZ-1:0] CTRL = 5'd16;
    localparam logic [ASZ-1:0] STAT = 5'd17;

    logic           clk;
    logic           _rst;
    logic [ASZ-1:0] awaddr;
    logic           awvalid;
    logic           awready;
    logic [DSZ-1:0] wdata;
    logic           wvalid;
    logic           wready;
    logic           bresp;
    logic           bvalid;
    logic           bready;
    logic [ASZ-1:0] araddr;
    logic           arvalid;
    logic           arready;
    logic [DSZ-1:0] rdata;
    logic           rresp;
    logic           rvalid;
    logic           rready;
    logic [1:0]     dbg_wr;
    logic           dbg_rd;
`ifdef AXI_LITE_MUL_IRQ_EN
    logic           irq;
`endif

    int checks;
    int errors;

    axi4_lite_mul_slave #(.SZ(SZ), .DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk            (clk),
        ._rst           (_rst),
        .awaddr         (awaddr),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wvalid         (wvalid),
        .wready         (wready),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
`ifdef AXI_LITE_MUL_IRQ_EN
        .irq            (irq),
`endif
        .dbg_wr_state_o (dbg_wr),
        .dbg_rd_state_o (dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [ASZ-1:0] addr, input logic [DSZ-1:0] data,
                             output logic resp);
        bit aw_hs, w_hs;
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            n++;
        end
        while (!bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%0d got=no_bvalid exp=bvalid", addr);
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            resp = 1'bx;
        end else begin
            resp = bresp;
            @(posedge clk);
            @(negedge clk);
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [ASZ-1:0] addr, output logic [DSZ-1:0] data,
                            output logic resp);
        bit hs;
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            hs = arready;
            @(posedge clk);
            @(negedge clk);
            if (hs) arvalid = 1'b0;
            n++;
        end
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%0d got=no_rvalid exp=rvalid", addr);
            arvalid = 1'b0; rready = 1'b0;
            data = 'x; resp = 1'bx;
        end else begin
            data = rdata;
            resp = rresp;
            @(posedge clk);
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic set_operands(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
        logic r;
        for (int k = 0; k < 4; k++) begin
            axi_write(5'(k), a[k*8 +: 8], r);
            checks++;
            if (r !== 1'b1) begin
                errors++;
                $display("FAIL operand_write_a%0d got=%b exp=1", k, r);
            end
            axi_write(5'(4 + k), b[k*8 +: 8], r);
            checks++;
            if (r !== 1'b1) begin
                errors++;
                $display("FAIL operand_write_b%0d got=%b exp=1", k, r);
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        logic [DSZ-1:0] d;
        logic r;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            axi_read(STAT, d, r);
            if (d[1] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [DSZ-1:0] d;
        logic r;
        checks++;
        if ({awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata});
        end
        checks++;
        if ({dbg_wr, dbg_rd} !== 3'd0) begin
            errors++;
            $display("FAIL reset_fsm_state got=%b exp=000", {dbg_wr, dbg_rd});
        end
`ifdef AXI_LITE_MUL_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
`endif
        @(negedge clk);
        _rst = 1'b1;
        axi_read(STAT, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL reset_status got=%b/%h exp=1/00", r, d);
        end
        axi_read(RES0, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL reset_res0 got=%b/%h exp=1/00", r, d);
        end
    endtask

    task automatic test_mul_basic;
        logic [DSZ-1:0] d;
        logic r;
        logic [7:0] exp_res [8];
        exp_res = '{8'hCB, 8'hF4, 8'hDA, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00};
        set_operands(32'd12551, 32'd41245);
        axi_write(CTRL, 8'h01, r);
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL basic_start_resp got=%b exp=1", r);
        end
        // Returned one cycle after busy rose; this read samples the 32nd busy edge.
        repeat (29) @(negedge clk);
        axi_read(STAT, d, r);
        checks++;
        if ({r, d} !== 9'h101) begin
            errors++;
            $display("FAIL basic_busy_at_32 got=%b/%h exp=1/01", r, d);
        end
        axi_read(STAT, d, r);
        checks++;
        if ({r, d} !== 9'h102) begin
            errors++;
            $display("FAIL basic_done_after_32 got=%b/%h exp=1/02", r, d);
        end
        for (int j = 0; j < 8; j++) begin
            axi_read(5'(8 + j), d, r);
            checks++;
            if ({r, d} !== {1'b1, exp_res[j]}) begin
                errors++;
                $display("FAIL basic_res%0d got=%b/%h exp=1/%h", j, r, d, exp_res[j]);
            end
        end
    endtask

    task automatic test_busy_errors;
        logic [DSZ-1:0] d;
        logic r;
        bit ok;
        set_operands(32'd3, 32'd5);
        axi_write(CTRL, 8'h01, r);
        axi_write(5'd0, 8'h99, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL busy_write_a got=%b exp=0", r);
        end
        axi_write(CTRL, 8'h01, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got=%b exp=0", r);
        end
        axi_read(RES0, d, r);
        checks++;
        if ({r, d} !== 9'h000) begin
            errors++;
            $display("FAIL busy_read_res got=%b/%h exp=0/00", r, d);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_wait_done got=timeout exp=done");
        end
        axi_read(RES0, d, r);
        checks++;
        if ({r, d} !== 9'h10F) begin
            errors++;
            $display("FAIL busy_res0 got=%b/%h exp=1/0f", r, d);
        end
        axi_read(5'd9, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL busy_res1 got=%b/%h exp=1/00", r, d);
        end
        axi_read(5'd0, d, r);
        checks++;
        if ({r, d} !== 9'h103) begin
            errors++;
            $display("FAIL busy_a0_kept got=%b/%h exp=1/03", r, d);
        end
    endtask

    task automatic test_mul_max;
        logic [DSZ-1:0] d;
        logic r;
        bit ok;
        logic [7:0] exp_res [8];
        exp_res = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        set_operands(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        axi_write(CTRL, 8'h01, r);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL max_wait_done got=timeout exp=done");
        end
        for (int j = 0; j < 8; j++) begin
            axi_read(5'(8 + j), d, r);
            checks++;
            if ({r, d} !== {1'b1, exp_res[j]}) begin
                errors++;
                $display("FAIL max_res%0d got=%b/%h exp=1/%h", j, r, d, exp_res[j]);
            end
        end
        axi_read(STAT, d, r);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL max_done_sticky got=%h exp=02", d);
        end
        axi_write(CTRL, 8'h02, r);
        axi_read(STAT, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL max_clr_done got=%h exp=00", d);
        end
        axi_write(CTRL, 8'h03, r);
        axi_read(STAT, d, r);
        checks++;
        if ({r, d} !== 9'h101) begin
            errors++;
            $display("FAIL start_beats_clr got=%b/%h exp=1/01", r, d);
        end
        wait_done(ok);
    endtask

    task automatic test_mul_zero;
        logic [DSZ-1:0] d;
        logic r;
        bit ok;
        set_operands(32'd0, 32'hFFFF_FFFF);
        axi_write(CTRL, 8'h01, r);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_wait_done got=timeout exp=done");
        end
        for (int j = 0; j < 8; j++) begin
            axi_read(5'(8 + j), d, r);
            checks++;
            if ({r, d} !== 9'h100) begin
                errors++;
                $display("FAIL zero_res%0d got=%b/%h exp=1/00", j, r, d);
            end
        end
    endtask

    task automatic test_w_before_aw;
        logic [DSZ-1:0] d;
        logic r;
        int n;
        int bad;
        @(negedge clk);
        wdata = 8'h5A; wvalid = 1'b1; bready = 1'b0;
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_wready got=%b exp=1", wready);
        end
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            errors++;
            $display("FAIL wfirst_wait_state got=%b exp=100", {awready, wready, bvalid});
        end
        awaddr = 5'd1; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || bresp !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wfirst_b_hold got=%0d_bad_cycles exp=0", bad);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wfirst_single_b got=%0d_extra_cycles exp=0", bad);
        end
        axi_read(5'd1, d, r);
        checks++;
        if ({r, d} !== 9'h15A) begin
            errors++;
            $display("FAIL wfirst_a1 got=%b/%h exp=1/5a", r, d);
        end
    endtask

    task automatic test_errors;
        logic [DSZ-1:0] d;
        logic r;
        axi_read(5'd18, d, r);
        checks++;
        if ({r, d} !== 9'h000) begin
            errors++;
            $display("FAIL err_read_18 got=%b/%h exp=0/00", r, d);
        end
        axi_read(5'd31, d, r);
        checks++;
        if ({r, d} !== 9'h000) begin
            errors++;
            $display("FAIL err_read_31 got=%b/%h exp=0/00", r, d);
        end
        axi_write(RES0, 8'h77, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL err_write_res got=%b exp=0", r);
        end
        axi_write(STAT, 8'h03, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL err_write_status got=%b exp=0", r);
        end
        axi_write(5'd20, 8'h01, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL err_write_unmapped got=%b exp=0", r);
        end
        axi_read(STAT, d, r);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL err_no_state_change got=%h exp=02", d);
        end
    endtask

    task automatic test_simultaneous;
        logic [DSZ-1:0] d;
        logic [DSZ-1:0] rd_got;
        logic r, rr_got, b_got;
        bit got_r, got_b;
        axi_write(5'd0, 8'h11, r);
        @(negedge clk);
        awaddr = 5'd0; wdata = 8'h22; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 5'd0; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        got_r = 1'b0; got_b = 1'b0;
        rd_got = 'x; rr_got = 1'bx; b_got = 1'bx;
        for (int i = 0; i < 10 && !(got_r && got_b); i++) begin
            if (rvalid && !got_r) begin
                got_r = 1'b1; rd_got = rdata; rr_got = rresp;
            end
            if (bvalid && !got_b) begin
                got_b = 1'b1; b_got = bresp;
            end
            @(negedge clk);
        end
        bready = 1'b0; rready = 1'b0;
        checks++;
        if ({got_r, rr_got, rd_got} !== 10'h311) begin
            errors++;
            $display("FAIL simul_read_old got=%b/%b/%h exp=1/1/11", got_r, rr_got, rd_got);
        end
        checks++;
        if ({got_b, b_got} !== 2'b11) begin
            errors++;
            $display("FAIL simul_write_resp got=%b/%b exp=1/1", got_b, b_got);
        end
        axi_read(5'd0, d, r);
        checks++;
        if ({r, d} !== 9'h122) begin
            errors++;
            $display("FAIL simul_a0_new got=%b/%h exp=1/22", r, d);
        end
    endtask

    task automatic test_reset_mid;
        logic [DSZ-1:0] d;
        logic r;
        int bad;
        set_operands(32'd12551, 32'd41245);
        axi_write(CTRL, 8'h01, r);
        axi_read(STAT, d, r);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL mid_busy_before_reset got=%h exp=01", d);
        end
        repeat (5) @(negedge clk);
        #2;
        _rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata});
        end
        repeat (2) @(negedge clk);
        _rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bvalid !== 1'b0 || rvalid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_no_response got=%0d_cycles exp=0", bad);
        end
        axi_read(STAT, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL mid_status got=%b/%h exp=1/00", r, d);
        end
        axi_read(5'd11, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL mid_res3 got=%b/%h exp=1/00", r, d);
        end
        axi_read(5'd0, d, r);
        checks++;
        if ({r, d} !== 9'h100) begin
            errors++;
            $display("FAIL mid_a0 got=%b/%h exp=1/00", r, d);
        end
    endtask

`ifdef AXI_LITE_MUL_IRQ_EN
    task automatic test_irq;
        logic r;
        bit ok;
        set_operands(32'd7, 32'd9);
        axi_write(CTRL, 8'h05, r);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_low_while_busy got=%b exp=0", irq);
        end
        wait_done(ok);
        checks++;
        if (!ok || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_with_done got=%b exp=1", irq);
        end
        axi_write(CTRL, 8'h06, r);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr_done got=%b exp=0", irq);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        _rst = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_mul_basic;
        test_busy_errors;
        test_mul_max;
        test_mul_zero;
        test_w_before_aw;
        test_errors;
        test_simultaneous;
        test_reset_mid;
`ifdef AXI_LITE_MUL_IRQ_EN
        test_irq;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
